// File: rtl/adder_accum_pkg.sv
// Shared types and helpers for the sign-magnitude accumulation controller.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package adder_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Widest sign-magnitude word the helpers handle.
  localparam int SM_MAXW = 64;

  // Positive zero: sign clear, magnitude clear. Slice to the word width in use.
  localparam logic [SM_MAXW-1:0] SM_POS_ZERO = '0;

  // Magnitude wrap for an n-bit sign-magnitude add: only same-sign operands
  // can wrap, and they do when the magnitude sum carries out of bit n-2.
  function automatic logic sm_wrap(input logic [SM_MAXW-1:0] a,
                                   input logic [SM_MAXW-1:0] b,
                                   input int unsigned n);
    logic [SM_MAXW-1:0] mask;
    logic [SM_MAXW:0]   sum;
    logic               sa;
    logic               sb;
    mask = (SM_MAXW'(1) << (n - 1)) - SM_MAXW'(1);
    sa   = |((a >> (n - 1)) & SM_MAXW'(1));
    sb   = |((b >> (n - 1)) & SM_MAXW'(1));
    sum  = {1'b0, a & mask} + {1'b0, b & mask};
    return (sa == sb) && (|(sum >> (n - 1)));
  endfunction

endpackage

// File: rtl/adder_accum_ctrl_adder.sv
// Combinational sign-magnitude adder: same signs add magnitudes (modulo), else subtract.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the caller decides when the sum is used.
module adder #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum
);

  logic         sa;
  logic         sb;
  logic [N-2:0] ma;
  logic [N-2:0] mb;

  assign sa = a[N-1];
  assign sb = b[N-1];
  assign ma = a[N-2:0];
  assign mb = b[N-2:0];

  // Pick add or subtract by sign; an exact cancellation always yields +0.
  always_comb begin
    sum = '0;
    if (sa == sb) begin
      sum = {sa, ma + mb};
    end else if (ma > mb) begin
      sum = {sa, ma - mb};
    end else if (mb > ma) begin
      sum = {sb, mb - ma};
    end
  end

endmodule

// File: rtl/adder_accum_ctrl.sv
// Sums a run of cfg_terms sign-magnitude terms through one shared adder; sticky wrap flag.
// Latency: out_valid rises the cycle after the last term's handshake; len+1 cycles per result.
// Backpressure: in_ready low while a result is held; result held until out_ready.
module adder_accum_ctrl
  import adder_accum_pkg::*;
#(
  parameter  int N         = 16,
  parameter  int MAX_TERMS = 32,
  localparam int CW        = $clog2(MAX_TERMS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic [CW-1:0] cfg_terms,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic          out_ovf,
  output logic          busy
);

  state_t        state_q, state_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] len_q, len_d;
  logic          ovf_q, ovf_d;

  logic          in_fire;
  logic          out_fire;
  logic [N-1:0]  add_a;
  logic [N-1:0]  add_sum;
  logic          wrap;
  logic [CW-1:0] first_len;

  // Handshakes depend on registered state only, so in_ready never loops back from inputs.
  assign in_ready  = (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = acc_q;
  assign out_ovf   = ovf_q;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // A run's first term starts from +0 rather than the stale previous result.
  assign add_a = (state_q == IDLE) ? SM_POS_ZERO[N-1:0] : acc_q;
  assign wrap  = sm_wrap(SM_MAXW'(add_a), SM_MAXW'(in_data), N);

  // Run length: zero means a single term, anything above the limit is clamped.
  assign first_len = (cfg_terms == '0) ? CW'(1) :
                     (cfg_terms > CW'(MAX_TERMS)) ? CW'(MAX_TERMS) : cfg_terms;

  adder #(.N(N)) u_adder (
    .a   (add_a),
    .b   (in_data),
    .sum (add_sum)
  );

  // Next-state and datapath update; clear overrides every other action.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_fire) begin
          len_d   = first_len;
          acc_d   = add_sum;
          cnt_d   = CW'(1);
          ovf_d   = 1'b0;
          state_d = (first_len == CW'(1)) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (in_fire) begin
          acc_d = add_sum;
          cnt_d = cnt_q + CW'(1);
          ovf_d = ovf_q | wrap;
          if ((cnt_q + CW'(1)) == len_q) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_fire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d = IDLE;
      acc_d   = SM_POS_ZERO[N-1:0];
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= SM_POS_ZERO[N-1:0];
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: doc/adder_accum_ctrl.md
Name: adder_accum_ctrl

Overview:
Sequencer that time-multiplexes one combinational sign-magnitude `adder` to sum a run of cfg_terms input samples into a single result. It is used for tap accumulation in the equalizer datapath. Input is a valid/ready stream of sign-magnitude words and output is a valid/ready result with a sticky overflow flag. Each accepted term costs one adder pass, and a new result starts only after the previous one is taken.

Parameters:
N, 16, total word width; sign-magnitude, bit N-1 = sign, bits N-2:0 = magnitude
MAX_TERMS, 32, largest supported run length
CW, $clog2(MAX_TERMS+1), width of cfg_terms and the term counter (derived, not overridden)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous reset, active-low
clear  in  1  synchronous abort of the current run
cfg_terms  in  CW  run length; sampled on the first accepted term of a run
in_valid  in  1  input term valid
in_ready  out  1  controller can accept a term
in_data  in  N  input term, sign-magnitude
out_valid  out  1  result valid
out_ready  in  1  downstream takes the result
out_data  out  N  accumulated sum, sign-magnitude
out_ovf  out  1  a magnitude wrap occurred during this run (sticky)
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, acc=+0 (all zeros), cnt=0, len=0, ovf=0.
  - out_valid=0, out_data=0, out_ovf=0, busy=0, in_ready=1 after release.
- States:
  - IDLE: waiting for the first term.
  - ACCUM: run in progress.
  - DONE: result held on the output.
- Handshakes:
  - Input: a term transfers when in_valid && in_ready.
  - in_ready = (state != DONE). It is driven from registered state only, never from in_valid or clear.
  - Output: a result transfers when out_valid && out_ready.
- IDLE + input transfer:
  - len <= (cfg_terms==0 ? 1 : min(cfg_terms, MAX_TERMS)).
  - acc <= adder(+0, in_data); cnt <= 1; ovf <= 0.
  - Next state: DONE if len==1, else ACCUM.
- ACCUM + input transfer:
  - acc <= adder(acc, in_data); cnt <= cnt+1; ovf <= ovf | wrap.
  - Go to DONE when cnt+1 == len.
  - Idle cycles (in_valid low) hold all state.
- DONE:
  - out_valid=1; out_data=acc and out_ovf=ovf, both stable until transfer.
  - On output transfer go to IDLE. acc and ovf are cleared on the next run's first term, not on the transfer.
- Latency: out_valid rises in the cycle after the handshake of the last term. Throughput is len+1 cycles per result at full rate.
- Arithmetic:
  - The shared `adder` is instantiated with operand a=acc, b=in_data.
  - Same sign: magnitudes add modulo 2^(N-1) and the sign is kept.
  - Different signs: the larger magnitude minus the smaller, with the sign of the larger. A zero difference gives +0.
- wrap = (acc[N-1]==in_data[N-1]) && ({1'b0,acc[N-2:0]} + {1'b0,in_data[N-2:0]} >= 2^(N-1)).
  - The controller computes this itself; the adder exposes no carry.
  - out_data is the wrapped value; no saturation.
- -0 input (0x8000 for N=16) is legal. -0 + -0 keeps -0; any mixed-sign zero result is +0.
- clear (synchronous) has priority over everything, in any state:
  - Next state IDLE; acc=+0, cnt=0, ovf=0, out_valid=0.
  - A term handshaking in the same cycle is discarded.
  - A result in DONE is dropped even if out_ready=1.
- Asynchronous reset mid-run or mid-DONE: outputs go to reset values immediately and the partial sum is lost.
- cfg_terms changes during a run are ignored until the next run starts.

Decomposition:
- Package adder_accum_pkg holds:
  - state_t enum {IDLE, ACCUM, DONE};
  - SM_POS_ZERO constant;
  - function sm_wrap(a, b) returning the wrap condition, for use in both RTL and the scoreboard.
- One sub-module: the existing `adder` (parameter N passed through). The FSM, counter and registers stay in adder_accum_ctrl.

Test Plan:
- cfg_terms=4; terms 0x0003, 0x0005, 0x8002, 0x0001 back-to-back -> out_data=0x0007, out_ovf=0; out_valid asserts exactly 1 cycle after the 4th handshake.
- cfg_terms=2; terms 0x0005, 0x8005 -> out_data=0x0000 (+0, never 0x8000), out_ovf=0.
- cfg_terms=2; terms 0x7FFF, 0x0001 -> out_data=0x0000, out_ovf=1. The next run (0x0001, 0x0001) gives 0x0002 with out_ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, out_data and out_ovf stable; in_ready=0 throughout; no term accepted.
- cfg_terms=4; clear pulsed after 2 terms (with in_valid=1 that cycle) -> IDLE next cycle, no out_valid. A fresh 4-term run 1, 2, 3, 4 (+) gives 0x000A.
- cfg_terms=0; single term 0x8009 -> out_data=0x8009 after one term. Then rst_n low while in DONE -> out_valid and out_data go to 0 without waiting for a clock edge.
